// File: rtl/delay_monitor.sv
// Interval checker for the periodic sig tick: acquires, locks after LOCK_CNT good intervals, flags early/late pulses.
// Optional DELAY_MON_STICKY_ERR_EN: err latches on the first fault until rst.
module delay_monitor #(
    parameter int PERIOD   = 22501,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 2,
    parameter int CBITS    = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic lock,
    output logic err,
    output logic early,
    output logic late,
    output logic flg
);
    typedef enum logic [1:0] {ACQ, VERIFY, TRACK, FAULT} state_t;

    localparam int GBITS = $clog2(LOCK_CNT + 1);
    localparam logic [CBITS:0]   WIN_LO  = (CBITS+1)'(PERIOD - TOL);
    localparam logic [CBITS:0]   WIN_HI  = (CBITS+1)'(PERIOD + TOL);
    localparam logic [CBITS:0]   ONE_W   = (CBITS+1)'(1);
    localparam logic [CBITS-1:0] LAST    = CBITS'(PERIOD + TOL - 1);
    localparam logic [CBITS-1:0] CMAX    = '1;
    localparam logic [CBITS-1:0] ONE_C   = CBITS'(1);
    localparam logic [GBITS-1:0] LOCK_M1 = GBITS'(LOCK_CNT - 1);
    localparam logic [GBITS-1:0] ONE_G   = GBITS'(1);

    state_t           state;
    logic [CBITS-1:0] cnt;
    logic [GBITS-1:0] good;
    logic [CBITS:0]   ival;
    logic             in_win;
    logic             late_cond;

    // Extra MSB keeps cnt+1 from wrapping when cnt is saturated.
    assign ival      = {1'b0, cnt} + ONE_W;
    assign in_win    = (ival >= WIN_LO) && (ival <= WIN_HI);
    assign late_cond = !sig && (cnt == LAST);
    assign flg       = (state != ACQ) && in_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACQ;
            cnt   <= '0;
            good  <= '0;
            lock  <= 1'b0;
            err   <= 1'b0;
            early <= 1'b0;
            late  <= 1'b0;
        end else begin
            early <= 1'b0;
            late  <= 1'b0;
`ifndef DELAY_MON_STICKY_ERR_EN
            err   <= 1'b0;
`endif
            if (sig)
                cnt <= '0;
            else if (cnt != CMAX)
                cnt <= cnt + ONE_C;

            case (state)
                ACQ: begin
                    if (sig) begin
                        state <= VERIFY;
                        good  <= '0;
                    end
                end
                VERIFY: begin
                    if (sig && in_win) begin
                        if (good == LOCK_M1) begin
                            state <= TRACK;
                            lock  <= 1'b1;
                            good  <= '0;
                        end else begin
                            good <= good + ONE_G;
                        end
                    end else if (sig || late_cond) begin
                        good <= '0;
                    end
                end
                TRACK: begin
                    // A pulse on the last legal slot is in-window, so early and late are exclusive.
                    if (sig && (ival < WIN_LO)) begin
                        state <= FAULT;
                        lock  <= 1'b0;
                        early <= 1'b1;
                        err   <= 1'b1;
                    end else if (late_cond) begin
                        state <= FAULT;
                        lock  <= 1'b0;
                        late  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                FAULT: begin
                    if (sig) begin
                        state <= VERIFY;
                        good  <= '0;
                    end
                end
                default: state <= ACQ;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_monitor.sv
// Randomized interval stimulus for delay_monitor checked against an interval-level reference model.
module tb_delay_monitor;
    localparam int PERIOD   = 10;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 2;
    localparam int CBITS    = 5;
    localparam int LO       = PERIOD - TOL;
    localparam int HI       = PERIOD + TOL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;
    logic lock, err, early, late, flg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles since last pulse plus coarse lock status.
    bit acquired, locked, faulted, err_seen, e_early, e_late;
    int run, elapsed;

    delay_monitor #(.PERIOD(PERIOD), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .CBITS(CBITS)) dut (
        .clk(clk), .rst(rst), .sig(sig),
        .lock(lock), .err(err), .early(early), .late(late), .flg(flg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    function automatic bit win(input int interval);
        return (interval >= LO) && (interval <= HI);
    endfunction

    task automatic model_reset();
        acquired = 0; locked = 0; faulted = 0; err_seen = 0;
        e_early = 0; e_late = 0; run = 0; elapsed = 0;
    endtask

    task automatic model_step(input bit s);
        int interval;
        e_early = 0;
        e_late  = 0;
        if (s) begin
            interval = elapsed + 1;
            if (!acquired) begin
                acquired = 1; run = 0;
            end else if (faulted) begin
                faulted = 0; run = 0;
            end else if (locked) begin
                if (interval < LO) begin
                    e_early = 1; locked = 0; faulted = 1;
                end
            end else if (win(interval)) begin
                run++;
                if (run == LOCK_CNT) begin
                    locked = 1; run = 0;
                end
            end else begin
                run = 0;
            end
            elapsed = 0;
        end else begin
            if (acquired && (elapsed + 1 == HI)) begin
                if (locked) begin
                    e_late = 1; locked = 0; faulted = 1;
                end else if (!faulted) begin
                    run = 0;
                end
            end
            elapsed++;
        end
        if (e_early || e_late) err_seen = 1;
    endtask

    task automatic compare_all();
        check("lock", lock, locked);
        check("early", early, e_early);
        check("late", late, e_late);
`ifdef DELAY_MON_STICKY_ERR_EN
        check("err", err, err_seen);
`else
        check("err", err, e_early | e_late);
`endif
        check("flg", flg, acquired && win(elapsed + 1));
    endtask

    task automatic tick(input bit s);
        @(negedge clk);
        sig = s;
        @(posedge clk);
        model_step(s);
        #1;
        compare_all();
    endtask

    task automatic send_interval(input int n);
        for (int i = 1; i < n; i++) tick(1'b0);
        tick(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sig = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_lock", lock, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_early", early, 1'b0);
        check("rst_late", late, 1'b0);
        check("rst_flg", flg, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        model_reset();
        do_reset();

        // Steady lock, then 20 clean pulses.
        tick(1'b1);
        for (int k = 0; k < 22; k++) send_interval(PERIOD);
        // Boundary intervals while locked.
        send_interval(LO);
        send_interval(HI);
        send_interval(PERIOD);
        // Early fault and re-lock.
        send_interval(7);
        for (int k = 0; k < 4; k++) send_interval(PERIOD);
        // Withheld pulse, then recover.
        send_interval(30);
        for (int k = 0; k < 4; k++) send_interval(PERIOD);
        send_interval(HI + 1);
        for (int k = 0; k < 4; k++) send_interval(PERIOD);
        send_interval(LO - 1);
        for (int k = 0; k < 4; k++) send_interval(PERIOD);
        // Reset mid-interval while locked; first pulse after release is odd.
        for (int k = 0; k < 4; k++) tick(1'b0);
        do_reset();
        send_interval(3);
        for (int k = 0; k < 4; k++) send_interval(PERIOD);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      send_interval(PERIOD);
            else if (r < 75) send_interval($urandom_range(0, 1) ? LO : HI);
            else if (r < 82) send_interval($urandom_range(7, 8));
            else if (r < 88) send_interval(HI + 1);
            else if (r < 93) send_interval($urandom_range(15, 40));
            else begin
                int w = $urandom_range(1, 8);
                for (int i = 0; i < w; i++) tick(1'b0);
                do_reset();
                send_interval($urandom_range(1, 20));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
